// File: rtl/branch_predict_ctrl.sv
// Branch predictor control: a 2-bit saturating counter table read in ID,
// trained in EX, and a one-cycle redirect/flush FSM raised on a mispredict.
module branch_predict_ctrl #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_pc,
    input  logic             id_is_branch,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_target,
    input  logic             stall,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {NORMAL, REDIRECT} state_t;

    state_t           state, state_next;
    logic [1:0]       table_q [ENTRIES];
    logic [IDX_W-1:0] id_idx, ex_idx;
    logic [1:0]       ctr_cur, ctr_next;
    logic             resolved, mispredict;

    assign id_idx     = id_pc[IDX_W+1:2];
    assign ex_idx     = ex_pc[IDX_W+1:2];
    assign pred_taken = id_is_branch & table_q[id_idx][1];

    // Resolution is gated by state, so EX contents seen during REDIRECT are ignored.
    assign resolved   = ex_valid & ex_is_branch & ~stall & (state == NORMAL);
    assign mispredict = resolved & (ex_taken != ex_pred_taken);

    assign redirect = (state == REDIRECT);
    assign flush    = (state == REDIRECT);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ctr_cur  = table_q[ex_idx];
        ctr_next = ctr_cur;
        if (ex_taken && ctr_cur != 2'd3)
            ctr_next = ctr_cur + 2'd1;
        else if (!ex_taken && ctr_cur != 2'd0)
            ctr_next = ctr_cur - 2'd1;
    end

    always_comb begin
        state_next = state;
        case (state)
            NORMAL:   if (mispredict) state_next = REDIRECT;
            REDIRECT: state_next = NORMAL;
            default:  state_next = NORMAL;
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= NORMAL;
        else
            state <= state_next;
    end

    // NOTE: the table is reset entry by entry, so it maps to flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                table_q[i] <= 2'b01;
        end else if (resolved) begin
            table_q[ex_idx] <= ctr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_pc <= 32'd0;
            br_count    <= '0;
            mp_count    <= '0;
        end else begin
            if (mispredict)
                redirect_pc <= ex_taken ? ex_target : ex_pc + 32'd4;
            if (resolved && br_count != '1)
                br_count <= br_count + CNT_ONE;
            if (mispredict && mp_count != '1)
                mp_count <= mp_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Testbench for branch_predict_ctrl: directed vector table, reset/saturation
// sequences, and randomized traffic checked against a rule-level model.
module tb_branch_predict_ctrl;

    localparam int IDX_W   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [31:0]      id_pc;
    logic             id_is_branch;
    logic             pred_taken;
    logic             ex_valid;
    logic             ex_is_branch;
    logic [31:0]      ex_pc;
    logic             ex_taken;
    logic             ex_pred_taken;
    logic [31:0]      ex_target;
    logic             stall;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mp_count;

    branch_predict_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_pc        (id_pc),
        .id_is_branch (id_is_branch),
        .pred_taken   (pred_taken),
        .ex_valid     (ex_valid),
        .ex_is_branch (ex_is_branch),
        .ex_pc        (ex_pc),
        .ex_taken     (ex_taken),
        .ex_pred_taken(ex_pred_taken),
        .ex_target    (ex_target),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .flush        (flush),
        .br_count     (br_count),
        .mp_count     (mp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] id_pc;
        logic        id_br;
        logic        ex_v;
        logic [31:0] ex_pc;
        logic        ex_t;
        logic        ex_p;
        logic [31:0] ex_tgt;
        logic        stall;
        logic        e_pred;
        logic        e_redir;
        logic [31:0] e_rpc;
        int          e_br;
        int          e_mp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [31:0] ipc, input logic ib,
                                input logic v, input logic [31:0] epc, input logic t,
                                input logic p, input logic [31:0] tgt, input logic s,
                                input logic ep, input logic er, input logic [31:0] erpc,
                                input int eb, input int em);
        vec_t x;
        x.rst = r;  x.id_pc = ipc; x.id_br = ib;
        x.ex_v = v; x.ex_pc = epc; x.ex_t = t; x.ex_p = p; x.ex_tgt = tgt; x.stall = s;
        x.e_pred = ep; x.e_redir = er; x.e_rpc = erpc; x.e_br = eb; x.e_mp = em;
        return x;
    endfunction

    task automatic drive(input vec_t v);
        rst           = v.rst;
        id_pc         = v.id_pc;
        id_is_branch  = v.id_br;
        ex_valid      = v.ex_v;
        ex_is_branch  = v.ex_v;
        ex_pc         = v.ex_pc;
        ex_taken      = v.ex_t;
        ex_pred_taken = v.ex_p;
        ex_target     = v.ex_tgt;
        stall         = v.stall;
    endtask

    task automatic idle_inputs();
        drive(mk(1'b0, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b0, 1'b0, 32'h0, 0, 0));
    endtask

    // Reference model: counter table, redirect flag and statistics as plain integers.
    int          m_cnt [1 << IDX_W];
    bit          m_redir;
    logic [31:0] m_rpc;
    int          m_br, m_mp;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & ((1 << IDX_W) - 1));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < (1 << IDX_W); i++) m_cnt[i] = 1;
        m_redir = 0; m_rpc = 32'd0; m_br = 0; m_mp = 0;
    endtask

    task automatic model_step();
        int k;
        if (m_redir) begin
            m_redir = 0;
        end else if (!stall && ex_valid && ex_is_branch) begin
            k = idx_of(ex_pc);
            m_cnt[k] = ex_taken ? ((m_cnt[k] == 3) ? 3 : m_cnt[k] + 1)
                                : ((m_cnt[k] == 0) ? 0 : m_cnt[k] - 1);
            m_br = (m_br == CNT_MAX) ? CNT_MAX : m_br + 1;
            if (ex_taken != ex_pred_taken) begin
                m_mp    = (m_mp == CNT_MAX) ? CNT_MAX : m_mp + 1;
                m_rpc   = ex_taken ? ex_target : ex_pc + 32'd4;
                m_redir = 1;
            end
        end
    endtask

    vec_t vecs [14];

    initial begin
        // Each row: inputs held for one cycle; expectations are outputs before that cycle's edge.
        vecs[0]  = mk(1, 32'h40, 1, 0, 32'h00, 0, 0, 32'h000, 0,  0, 0, 32'h000, 0, 0);
        vecs[1]  = mk(0, 32'h40, 1, 1, 32'h40, 1, 0, 32'h100, 0,  0, 0, 32'h000, 0, 0);
        vecs[2]  = mk(0, 32'h40, 1, 0, 32'h00, 0, 0, 32'h000, 0,  1, 1, 32'h100, 1, 1);
        vecs[3]  = mk(0, 32'h40, 1, 1, 32'h40, 1, 1, 32'h100, 0,  1, 0, 32'h100, 1, 1);
        vecs[4]  = mk(0, 32'h40, 0, 1, 32'h40, 1, 1, 32'h100, 0,  0, 0, 32'h100, 2, 1);
        vecs[5]  = mk(0, 32'h40, 1, 1, 32'h40, 1, 1, 32'h100, 0,  1, 0, 32'h100, 3, 1);
        vecs[6]  = mk(0, 32'h40, 1, 1, 32'h80, 0, 1, 32'h200, 0,  1, 0, 32'h100, 4, 1);
        vecs[7]  = mk(0, 32'h40, 1, 1, 32'h40, 0, 1, 32'h000, 0,  1, 1, 32'h084, 5, 2);
        vecs[8]  = mk(0, 32'h40, 1, 1, 32'h40, 0, 1, 32'h000, 1,  1, 0, 32'h084, 5, 2);
        vecs[9]  = mk(0, 32'h40, 1, 1, 32'h40, 0, 1, 32'h000, 1,  1, 0, 32'h084, 5, 2);
        vecs[10] = mk(0, 32'h40, 1, 1, 32'h40, 0, 1, 32'h000, 0,  1, 0, 32'h084, 5, 2);
        vecs[11] = mk(0, 32'h40, 1, 0, 32'h00, 0, 0, 32'h000, 1,  0, 1, 32'h044, 6, 3);
        vecs[12] = mk(0, 32'h40, 1, 0, 32'h00, 0, 0, 32'h000, 0,  0, 0, 32'h044, 6, 3);
        vecs[13] = mk(0, 32'h40, 1, 1, 32'h40, 1, 0, 32'h500, 0,  0, 0, 32'h044, 6, 3);

        rst = 1'b1;
        idle_inputs();
        rst = 1'b1;
        #1;
        check("reset_redirect", {31'd0, redirect}, 32'd0);
        check("reset_flush", {31'd0, flush}, 32'd0);

        // Directed vector table.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_pred", i), {31'd0, pred_taken}, {31'd0, vecs[i].e_pred});
            check($sformatf("v%0d_redirect", i), {31'd0, redirect}, {31'd0, vecs[i].e_redir});
            check($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].e_redir});
            check($sformatf("v%0d_rpc", i), redirect_pc, vecs[i].e_rpc);
            check($sformatf("v%0d_br", i), 32'(br_count), 32'(vecs[i].e_br));
            check($sformatf("v%0d_mp", i), 32'(mp_count), 32'(vecs[i].e_mp));
        end

        // Reset asserted mid-cycle while in REDIRECT aborts it without a clock edge.
        @(negedge clk);
        idle_inputs();
        #1;
        check("pre_rst_redirect", {31'd0, redirect}, 32'd1);
        check("pre_rst_rpc", redirect_pc, 32'h500);
        check("pre_rst_pred", {31'd0, pred_taken}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        check("rst_br", 32'(br_count), 32'd0);
        check("rst_mp", 32'(mp_count), 32'd0);
        check("rst_pred", {31'd0, pred_taken}, 32'd0);

        // Statistics saturation: more correctly predicted branches than the counter can hold.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            ex_valid = 1'b1; ex_is_branch = 1'b1; stall = 1'b0;
            ex_pc = 32'(i) << 2;
            ex_taken = i[0];
            ex_pred_taken = i[0];
            @(negedge clk);
        end
        ex_valid = 1'b0;
        #1;
        check("sat_br", 32'(br_count), 32'(CNT_MAX));
        check("sat_mp", 32'(mp_count), 32'd0);
        check("sat_redirect", {31'd0, redirect}, 32'd0);

        // Randomized traffic against the reference model.
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            id_pc         = $urandom;
            id_is_branch  = ($urandom_range(3) != 0);
            ex_valid      = ($urandom_range(3) != 0);
            ex_is_branch  = ($urandom_range(3) != 0);
            ex_pc         = $urandom;
            ex_taken      = $urandom_range(1) != 0;
            ex_target     = $urandom;
            stall         = ($urandom_range(3) == 0);
            ex_pred_taken = ($urandom_range(3) != 0) ? (m_cnt[idx_of(ex_pc)] >= 2)
                                                      : ($urandom_range(1) != 0);
            #1;
            check("rnd_pred", {31'd0, pred_taken},
                  {31'd0, id_is_branch && (m_cnt[idx_of(id_pc)] >= 2)});
            check("rnd_redirect", {31'd0, redirect}, {31'd0, m_redir});
            check("rnd_flush", {31'd0, flush}, {31'd0, m_redir});
            check("rnd_rpc", redirect_pc, m_rpc);
            check("rnd_br", 32'(br_count), 32'(m_br));
            check("rnd_mp", 32'(mp_count), 32'(m_mp));
            model_step();
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 The block SHALL have parameter IDX_W, default 4, meaning the prediction table index width (2^IDX_W entries).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the statistics counter width.
REQ-003 The block SHALL run on one clock and use an asynchronous, active-high reset: port clk (input, 1 bit, rising-edge clock), then port rst (input, 1 bit, async active-high reset).
REQ-004 id_pc  input  32  PC of the instruction in ID.
REQ-005 id_is_branch  input  1  ID instruction is a conditional branch.
REQ-006 pred_taken  output  1  prediction for the ID branch.
REQ-007 ex_valid  input  1  EX holds a valid instruction.
REQ-008 ex_is_branch  input  1  EX instruction is a conditional branch.
REQ-009 ex_pc  input  32  PC of the EX branch.
REQ-010 ex_taken  input  1  actual outcome from the branch condition unit.
REQ-011 ex_pred_taken  input  1  prediction carried down the pipeline with the branch.
REQ-012 ex_target  input  32  computed taken target.
REQ-013 stall  input  1  pipeline frozen this cycle.
REQ-014 redirect  output  1  fetch PC override.
REQ-015 redirect_pc  output  32  corrected fetch PC.
REQ-016 flush  output  1  squash IF/ID and ID/EX contents.
REQ-017 br_count  output  CNT_W  resolved branches.
REQ-018 mp_count  output  CNT_W  mispredictions.

Function
REQ-019 The table SHALL hold 2^IDX_W 2-bit saturating counters, indexed by pc[IDX_W+1:2].
REQ-020 pred_taken SHALL equal id_is_branch AND bit 1 of the counter at the id_pc index, combinationally.
REQ-021 A branch SHALL be resolved when ex_valid=1, ex_is_branch=1, stall=0, and state=NORMAL.
REQ-022 On a resolved branch, the counter at the ex_pc index SHALL update at the next rising edge:
  - +1 if ex_taken=1, saturating at 3;
  - -1 if ex_taken=0, saturating at 0.
REQ-023 A mispredict SHALL be a resolved branch with ex_taken != ex_pred_taken.
REQ-024 The FSM SHALL have exactly two states, NORMAL and REDIRECT.
  - NORMAL to REDIRECT on a mispredict.
  - REDIRECT to NORMAL unconditionally after exactly one cycle, regardless of stall.
REQ-025 On the mispredict edge, redirect_pc SHALL be registered as ex_target if ex_taken=1, else ex_pc+4 (modulo 2^32).
REQ-026 redirect and flush SHALL be 1 exactly while state=REDIRECT, and 0 otherwise.
REQ-027 redirect_pc SHALL hold its last registered value outside REDIRECT.
REQ-028 In REDIRECT, EX inputs SHALL be ignored: no table update, no statistics update, no new mispredict.
REQ-029 br_count SHALL increment on every resolved branch, saturating at all-ones.
REQ-030 mp_count SHALL increment on every mispredict, saturating at all-ones.
REQ-031 When stall=1 in NORMAL, the table, counters, and FSM SHALL hold their values.
REQ-032 Simultaneous ID read and EX write to the same index SHALL return the pre-update counter value (no bypass).

Reset
REQ-033 While rst=1, regardless of clk:
  - all table counters SHALL be 2'b01 (weakly not-taken);
  - state SHALL be NORMAL;
  - redirect and flush SHALL be 0;
  - redirect_pc SHALL be 0;
  - br_count and mp_count SHALL be 0.
REQ-034 Reset asserted while in REDIRECT SHALL abort the redirect immediately (redirect=0 and flush=0 while rst=1).

Verification
REQ-035 The bench SHALL cover these directed scenarios:
  - Reset, then id_pc=0x40, id_is_branch=1 -> pred_taken=0; br_count=0; mp_count=0; redirect=0.
  - Resolve pc=0x40 taken with pred 0, target 0x100 -> next cycle redirect=1, flush=1, redirect_pc=0x100, mp_count=1; one cycle later redirect=0.
  - Two more taken resolutions at 0x40 (pred 1) -> no redirect; pred_taken for 0x40 stays 1; counter saturates at 3 after a further taken.
  - Resolve not-taken at 0x80 with pred 1 -> redirect_pc=0x84; a branch presented in EX during the REDIRECT cycle -> no count or table change.
  - stall=1 with a valid mispredicting branch in EX -> no redirect and no count change; release stall -> redirect next cycle.
  - Assert rst during REDIRECT -> redirect=0 and flush=0 immediately; the table returns to 01 (pred_taken=0 for 0x40).
  - Preload br_count near all-ones and resolve a branch -> the count holds at all-ones.
